// File: rtl/clock_set_controller.sv
// clock_set_controller: button front end and time-setting sequencer for the
// four-digit clock display.
//   - Conditions three raw push-buttons (2-flop sync + debounce + rise pulse).
//   - Sequences the display mode SETUP/TIME24/SECONDS/TIME12.
//   - In SETUP, steps a cursor over hh:mm and edits a shadow copy of the time.
//   - On commit, issues a one-cycle load strobe to the timekeeper.
//   - Produces the blink phase for the digit being set.
//
// Optional build macro: SETUP_TIMEOUT_EN. When defined, SETUP aborts after
// TIMEOUT_CYCLES cycles with no inc/next activity.
//
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   btn_mode/next/inc     raw asynchronous active-high buttons
//   cur_hu/hl/mu/ml       live time digits from the timekeeper
//   mode                  00 SETUP, 01 TIME24, 10 SECONDS, 11 TIME12
//   location              digit under edit (0 = hours tens .. 3 = minutes units)
//   set_hu/hl/mu/ml       shadow time being edited
//   load                  one-cycle commit strobe
//   blink                 1 = selected digit visible, 0 = blanked
module clock_set_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned BLINK_HALF      = 25000000,
  parameter int unsigned TIMEOUT_CYCLES  = 1500000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic [1:0] cur_hu,
  input  logic [3:0] cur_hl,
  input  logic [2:0] cur_mu,
  input  logic [3:0] cur_ml,
  output logic [1:0] mode,
  output logic [1:0] location,
  output logic [1:0] set_hu,
  output logic [3:0] set_hl,
  output logic [2:0] set_mu,
  output logic [3:0] set_ml,
  output logic       load,
  output logic       blink
);

  localparam int unsigned NBTN = 3;
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned BL_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    RUN24  = 2'd0,
    RUNSEC = 2'd1,
    RUN12  = 2'd2,
    SET    = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Button conditioning: bit 0 = mode, bit 1 = next, bit 2 = inc
  // ---------------------------------------------------------------------------
  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] pulse;
  logic            p_mode;
  logic            p_next;
  logic            p_inc;

  assign btn_raw = {btn_inc, btn_next, btn_mode};

  for (genvar g = 0; g < NBTN; g++) begin : g_btn
    logic            sync1_q;
    logic            sync2_q;
    logic            lvl_q;
    logic            lvl_d;
    logic            rise;
    logic [DB_W-1:0] cnt_q;
    logic [DB_W-1:0] cnt_d;

    // Accept a new level once it has differed from the old one for
    // DEBOUNCE_CYCLES consecutive samples; a rising acceptance is the pulse.
    always_comb begin
      lvl_d = lvl_q;
      cnt_d = '0;
      rise  = 1'b0;
      if (sync2_q != lvl_q) begin
        if (cnt_q == DB_LAST) begin
          lvl_d = sync2_q;
          rise  = sync2_q;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        lvl_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= btn_raw[g];
        sync2_q <= sync1_q;
        lvl_q   <= lvl_d;
        cnt_q   <= cnt_d;
      end
    end

    assign pulse[g] = rise;
  end

  assign p_mode = pulse[0];
  assign p_next = pulse[1];
  assign p_inc  = pulse[2];

  // ---------------------------------------------------------------------------
  // Optional setup inactivity timeout
  // ---------------------------------------------------------------------------
  logic timeout;

  state_t state_q, state_d;

`ifdef SETUP_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Runs only while idle in SET; any inc/next restarts the window.
  always_comb begin
    to_cnt_d = '0;
    timeout  = 1'b0;
    if (state_q == SET && !p_inc && !p_next) begin
      if (to_cnt_q == TO_LAST) begin
        timeout = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Mode / setup sequencer
  // ---------------------------------------------------------------------------
  state_t          ret_q, ret_d;
  logic [1:0]      mode_q, mode_d;
  logic [1:0]      loc_q, loc_d;
  logic [1:0]      set_hu_q, set_hu_d;
  logic [3:0]      set_hl_q, set_hl_d;
  logic [2:0]      set_mu_q, set_mu_d;
  logic [3:0]      set_ml_q, set_ml_d;
  logic            load_q, load_d;
  logic            blink_q, blink_d;
  logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;

  // Next-state, shadow-digit and blink logic.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    loc_d       = loc_q;
    set_hu_d    = set_hu_q;
    set_hl_d    = set_hl_q;
    set_mu_d    = set_mu_q;
    set_ml_d    = set_ml_q;
    load_d      = 1'b0;
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;

    case (state_q)
      RUN24, RUNSEC, RUN12: begin
        blink_d     = 1'b1;
        blink_cnt_d = '0;
        if (p_mode) begin
          case (state_q)
            RUN24:   state_d = RUNSEC;
            RUNSEC:  state_d = RUN12;
            default: state_d = RUN24;
          endcase
        end else if (p_next) begin
          state_d  = SET;
          ret_d    = state_q;
          loc_d    = 2'd0;
          set_hu_d = cur_hu;
          set_hl_d = cur_hl;
          set_mu_d = cur_mu;
          set_ml_d = cur_ml;
        end
      end

      SET: begin
        if (p_mode || timeout) begin
          // Abort: shadow digits are kept, nothing is loaded.
          state_d     = ret_q;
          blink_d     = 1'b1;
          blink_cnt_d = '0;
        end else if (p_next) begin
          blink_d     = 1'b1;
          blink_cnt_d = '0;
          if (loc_q == 2'd3) begin
            load_d  = 1'b1;
            state_d = ret_q;
            loc_d   = 2'd0;
          end else begin
            loc_d = loc_q + 2'd1;
          end
        end else if (p_inc) begin
          blink_d     = 1'b1;
          blink_cnt_d = '0;
          case (loc_q)
            2'd0: begin
              if (set_hu_q == 2'd2) begin
                set_hu_d = 2'd0;
              end else begin
                set_hu_d = set_hu_q + 2'd1;
                // Keep hours legal when tens becomes 2 (max 23).
                if (set_hu_d == 2'd2 && set_hl_q > 4'd3) begin
                  set_hl_d = 4'd0;
                end
              end
            end
            2'd1: begin
              if ((set_hu_q == 2'd2 && set_hl_q >= 4'd3) || set_hl_q >= 4'd9) begin
                set_hl_d = 4'd0;
              end else begin
                set_hl_d = set_hl_q + 4'd1;
              end
            end
            2'd2: begin
              if (set_mu_q >= 3'd5) begin
                set_mu_d = 3'd0;
              end else begin
                set_mu_d = set_mu_q + 3'd1;
              end
            end
            default: begin
              if (set_ml_q >= 4'd9) begin
                set_ml_d = 4'd0;
              end else begin
                set_ml_d = set_ml_q + 4'd1;
              end
            end
          endcase
        end else begin
          if (blink_cnt_q == BL_LAST) begin
            blink_d     = ~blink_q;
            blink_cnt_d = '0;
          end else begin
            blink_cnt_d = blink_cnt_q + BL_W'(1);
          end
        end
      end

      default: state_d = RUN24;
    endcase

    case (state_d)
      RUN24:   mode_d = 2'b01;
      RUNSEC:  mode_d = 2'b10;
      RUN12:   mode_d = 2'b11;
      default: mode_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN24;
      ret_q       <= RUN24;
      mode_q      <= 2'b01;
      loc_q       <= 2'd0;
      set_hu_q    <= 2'd0;
      set_hl_q    <= 4'd0;
      set_mu_q    <= 3'd0;
      set_ml_q    <= 4'd0;
      load_q      <= 1'b0;
      blink_q     <= 1'b1;
      blink_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      mode_q      <= mode_d;
      loc_q       <= loc_d;
      set_hu_q    <= set_hu_d;
      set_hl_q    <= set_hl_d;
      set_mu_q    <= set_mu_d;
      set_ml_q    <= set_ml_d;
      load_q      <= load_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign mode     = mode_q;
  assign location = loc_q;
  assign set_hu   = set_hu_q;
  assign set_hl   = set_hl_q;
  assign set_mu   = set_mu_q;
  assign set_ml   = set_ml_q;
  assign load     = load_q;
  assign blink    = blink_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed self-checking bench for clock_set_controller with short debounce,
// blink and timeout constants. Honors SETUP_TIMEOUT_EN like the design.
module tb_clock_set_controller;

  logic       clk;
  logic       rst_n;
  logic       btn_mode, btn_next, btn_inc;
  logic [1:0] cur_hu;
  logic [3:0] cur_hl;
  logic [2:0] cur_mu;
  logic [3:0] cur_ml;
  logic [1:0] mode, location;
  logic [1:0] set_hu;
  logic [3:0] set_hl;
  logic [2:0] set_mu;
  logic [3:0] set_ml;
  logic       load, blink;

  int n_checks = 0;
  int n_errors = 0;
  int load_cnt = 0;
  logic [12:0] load_set = '0;

  clock_set_controller #(
    .DEBOUNCE_CYCLES(4),
    .BLINK_HALF     (8),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_mode(btn_mode),
    .btn_next(btn_next),
    .btn_inc (btn_inc),
    .cur_hu  (cur_hu),
    .cur_hl  (cur_hl),
    .cur_mu  (cur_mu),
    .cur_ml  (cur_ml),
    .mode    (mode),
    .location(location),
    .set_hu  (set_hu),
    .set_hl  (set_hl),
    .set_mu  (set_mu),
    .set_ml  (set_ml),
    .load    (load),
    .blink   (blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count load strobes and capture the shadow time seen with each one.
  always @(negedge clk) begin
    if (load) begin
      load_cnt = load_cnt + 1;
      load_set = {set_hu, set_hl, set_mu, set_ml};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] pack(input int hu, input int hl, input int mu, input int ml);
    return {2'(hu), 4'(hl), 3'(mu), 4'(ml)};
  endfunction

  task automatic check_set(input string tag, input int hu, input int hl, input int mu, input int ml);
    check(tag, 32'({set_hu, set_hl, set_mu, set_ml}), 32'(pack(hu, hl, mu, ml)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assert a button and wait until its action is visible (2 sync + 4 debounce).
  // which: 0 mode, 1 next, 2 inc, 3 mode+inc together.
  task automatic push(input int which);
    case (which)
      0:       btn_mode = 1'b1;
      1:       btn_next = 1'b1;
      2:       btn_inc  = 1'b1;
      default: begin btn_mode = 1'b1; btn_inc = 1'b1; end
    endcase
    repeat (6) tick();
  endtask

  task automatic release_btns();
    btn_mode = 1'b0;
    btn_next = 1'b0;
    btn_inc  = 1'b0;
    repeat (8) tick();
  endtask

  task automatic press(input int which);
    push(which);
    release_btns();
  endtask

  int loads_before;

  initial begin
    rst_n    = 1'b0;
    btn_mode = 1'b0;
    btn_next = 1'b0;
    btn_inc  = 1'b0;
    cur_hu   = 2'd0;
    cur_hl   = 4'd0;
    cur_mu   = 3'd0;
    cur_ml   = 4'd0;
    repeat (3) tick();

    // Reset state
    check("rst_mode", 32'(mode), 32'd1);
    check("rst_loc", 32'(location), 32'd0);
    check_set("rst_set", 0, 0, 0, 0);
    check("rst_load", 32'(load), 32'd0);
    check("rst_blink", 32'(blink), 32'd1);
    rst_n = 1'b1;
    repeat (2) tick();

    // Short glitch is rejected
    btn_mode = 1'b1;
    repeat (3) tick();
    release_btns();
    check("short_press", 32'(mode), 32'd1);

    // Long hold: exactly one step, at debounce latency
    btn_mode = 1'b1;
    repeat (5) tick();
    check("mode_pre", 32'(mode), 32'd1);
    tick();
    check("mode_step", 32'(mode), 32'd2);
    repeat (14) tick();
    check("mode_hold", 32'(mode), 32'd2);
    release_btns();
    check("mode_release", 32'(mode), 32'd2);

    press(0);
    check("mode_run12", 32'(mode), 32'd3);

    // inc ignored in run state
    press(2);
    check("inc_in_run_mode", 32'(mode), 32'd3);
    check_set("inc_in_run_set", 0, 0, 0, 0);

    // Enter SET from RUN12 with live time 19:47
    cur_hu = 2'd1; cur_hl = 4'd9; cur_mu = 3'd4; cur_ml = 4'd7;
    push(1);
    check("enter_mode", 32'(mode), 32'd0);
    check("enter_loc", 32'(location), 32'd0);
    check_set("enter_set", 1, 9, 4, 7);
    check("enter_blink", 32'(blink), 32'd1);
    release_btns();
    cur_hu = 2'd0; cur_hl = 4'd8; cur_mu = 3'd2; cur_ml = 4'd6;
    tick();
    check_set("cur_isolated", 1, 9, 4, 7);

    // hu 1->2 forces hl 9 -> 0; then check blink cadence
    push(2);
    check_set("hu_to_2", 2, 0, 4, 7);
    check("blink_after_inc", 32'(blink), 32'd1);
    repeat (7) tick();
    check("blink_7", 32'(blink), 32'd1);
    tick();
    check("blink_8", 32'(blink), 32'd0);
    repeat (8) tick();
    check("blink_16", 32'(blink), 32'd1);
    release_btns();

    // hl with hu = 2 wraps after 3
    press(1);
    check("loc_1", 32'(location), 32'd1);
    press(2); press(2); press(2);
    check_set("hl_3", 2, 3, 4, 7);
    press(2);
    check_set("hl_wrap", 2, 0, 4, 7);
    press(2);

    // mu wraps after 5
    press(1);
    check("loc_2", 32'(location), 32'd2);
    press(2);
    check_set("mu_5", 2, 1, 5, 7);
    press(2);
    check_set("mu_wrap", 2, 1, 0, 7);
    press(2);

    // ml wraps after 9
    press(1);
    check("loc_3", 32'(location), 32'd3);
    press(2); press(2);
    check_set("ml_9", 2, 1, 1, 9);
    press(2);
    check_set("ml_wrap", 2, 1, 1, 0);

    // Commit: one-cycle load, return to RUN12
    loads_before = load_cnt;
    btn_next = 1'b1;
    repeat (5) tick();
    check("load_pre", 32'(load), 32'd0);
    tick();
    check("load_hi", 32'(load), 32'd1);
    check("commit_mode", 32'(mode), 32'd3);
    check("commit_loc", 32'(location), 32'd0);
    check_set("commit_set", 2, 1, 1, 0);
    tick();
    check("load_lo", 32'(load), 32'd0);
    release_btns();
    check("load_count", 32'(load_cnt - loads_before), 32'd1);
    check("load_capture", 32'(load_set), 32'(pack(2, 1, 1, 0)));
    check_set("post_commit_set", 2, 1, 1, 0);

    // Abort wins over simultaneous inc
    press(1);
    check_set("reenter_set", 0, 8, 2, 6);
    loads_before = load_cnt;
    push(3);
    check("abort_mode", 32'(mode), 32'd3);
    check_set("abort_set", 0, 8, 2, 6);
    release_btns();
    check("abort_noload", 32'(load_cnt - loads_before), 32'd0);

    // Idle in SET
    loads_before = load_cnt;
    push(1);
    check("idle_enter", 32'(mode), 32'd0);
`ifdef SETUP_TIMEOUT_EN
    repeat (63) tick();
    check("timeout_pre", 32'(mode), 32'd0);
    tick();
    check("timeout_abort", 32'(mode), 32'd3);
    check("timeout_noload", 32'(load_cnt - loads_before), 32'd0);
    release_btns();
    push(1);
`else
    repeat (200) tick();
    check("no_timeout", 32'(mode), 32'd0);
    check("no_timeout_load", 32'(load_cnt - loads_before), 32'd0);
    release_btns();
    push(1);
`endif

    // Reset mid-setup returns to RUN24 at once, no load
    check("pre_reset_mode", 32'(mode), 32'd0);
    loads_before = load_cnt;
    rst_n = 1'b0;
    #1;
    check("midreset_mode", 32'(mode), 32'd1);
    check("midreset_load", 32'(load), 32'd0);
    release_btns();
    rst_n = 1'b1;
    repeat (4) tick();
    check("midreset_mode_after", 32'(mode), 32'd1);
    check("midreset_noload", 32'(load_cnt - loads_before), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
